nandy_control_unit: RTL and testbench

Instruction decoder and two-phase cycle sequencer for the Nandy CPU. It decodes the current 8-bit instruction, the internal `cycle` phase and the ALU carry into every datapath control strobe: memory, jump, register-file, ALU op and signal lines. The only state is the one-bit cycle-phase register, which gives instructions with `inst[7]=1` a fetch/memory phase followed by an execute phase. All other instructions complete in one phase.

---
 rtl/nandy_control_unit.sv | 86 ++++++++
 tb/tb_nandy_control_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/nandy_control_unit.sv
// Nandy CPU instruction decoder and two-phase cycle sequencer.
// Optional SIG one-hot decoder enabled by defining NANDY_CONTROL_SIG_EN.
module nandy_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst,
    input  logic       carry,
    output logic       cycle,
    output logic       M,
    output logic       S,
    output logic       J,
    output logic       LJ,
    output logic       CLI,
    output logic       LJR,
    output logic       MW,
    output logic       MC,
    output logic       RD,
    output logic       WR,
    output logic       Y,
    output logic       WA,
    output logic       ISP,
    output logic       WC,
    output logic [1:0] RS,
    output logic [3:0] ALU,
    output logic [7:0] SIG
);
    typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_t;

    phase_t phase, phaseNext;
    logic   c, aTerm, lowGrp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= PH_FIRST;
        else     phase <= phaseNext;
    end

    always_comb begin
        phaseNext = PH_FIRST;
        c      = (phase == PH_SECOND);
        lowGrp = ~inst[7] & ~inst[6] & ~inst[5];
        aTerm  = (inst[6] & ~inst[7]) | (c & inst[6] & ~inst[5]);
        cycle  = c;
        M      = 1'b0;
        S      = 1'b0;
        J      = 1'b0;
        LJ     = 1'b0;
        CLI    = 1'b0;
        LJR    = 1'b0;
        MW     = 1'b0;
        MC     = 1'b0;
        RD     = 1'b0;
        WR     = 1'b0;
        Y      = 1'b0;
        WA     = 1'b0;
        ISP    = 1'b0;
        WC     = 1'b0;
        RS     = 2'b00;
        ALU    = 4'b0000;
        SIG    = 8'h00;

        // Only i7=1 instructions take the second phase, and only once.
        if (inst[7] && !c) phaseNext = PH_SECOND;

        M   = inst[7] & ~inst[6] & c;
        S   = inst[4];
        J   = inst[7] & inst[6] & inst[5] & c & ~(carry & inst[4]);
        LJ  = lowGrp & inst[4] & ~inst[3];
        CLI = LJ & inst[1];
        LJR = LJ & inst[2];
        MW  = M & inst[5];
        MC  = inst[7] & ~c;
        RD  = lowGrp & ~inst[4] & inst[2];
        WR  = lowGrp & ~inst[4] & inst[3];
        Y   = inst[5];
        RS  = inst[1:0];
        WA  = (M & ~inst[5]) | (aTerm & ~(inst[4] & ~inst[3]));
        ISP = ~inst[7] & ~inst[6] & inst[5];
        WC  = (aTerm | ISP) & inst[4];
        ALU = inst[6] ? inst[3:0] : {~inst[7], 3'b000};
`ifdef NANDY_CONTROL_SIG_EN
        if (lowGrp && inst[4] && inst[3]) SIG = 8'b1 << inst[2:0];
`else
        SIG = 8'h00;
`endif
    end
endmodule

// File: tb/tb_nandy_control_unit.sv
// Self-checking bench: directed decode cases plus randomized instruction stream vs a spec model.
module tb_nandy_control_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inst;
    logic       carry;
    logic       cycle, M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] SIG;

    int   total = 0;
    int   bad   = 0;
    logic expCycle;

    always #5 clk = ~clk;

    nandy_control_unit dut (
        .clk(clk), .rst(rst), .inst(inst), .carry(carry), .cycle(cycle),
        .M(M), .S(S), .J(J), .LJ(LJ), .CLI(CLI), .LJR(LJR), .MW(MW), .MC(MC),
        .RD(RD), .WR(WR), .Y(Y), .WA(WA), .ISP(ISP), .WC(WC),
        .RS(RS), .ALU(ALU), .SIG(SIG)
    );

    // Reference decode from the instruction's field meaning, returned in output order.
    function automatic logic [28:0] model(input logic [7:0] i, input logic cr, input logic ph);
        logic [2:0] top;
        logic m, j, lj, rd, wr, wa, isp, wc, a, s;
        logic [3:0] alu;
        logic [7:0] sig;
        top = i[7:5];
        m   = (top inside {3'b100, 3'b101}) && ph;
        j   = (top == 3'b111) && ph && !(cr && i[4]);
        lj  = (top == 3'b000) && (i[4:3] == 2'b10);
        rd  = (top == 3'b000) && !i[4] && i[2];
        wr  = (top == 3'b000) && !i[4] && i[3];
        isp = (top == 3'b001);
        a   = (top inside {3'b010, 3'b011}) || (ph && (top == 3'b110 || top == 3'b010));
        s   = i[4];
        wa  = (m && !i[5]) || (a && !(i[4:3] == 2'b10));
        wc  = (a || isp) && i[4];
        alu = i[6] ? i[3:0] : (i[7] ? 4'd0 : 4'd8);
        sig = 8'h00;
`ifdef NANDY_CONTROL_SIG_EN
        if (top == 3'b000 && i[4:3] == 2'b11) sig = 8'(1 << i[2:0]);
`endif
        model = {ph, m, s, j, lj, lj && i[1], lj && i[2], m && i[5], i[7] && !ph,
                 rd, wr, i[5], wa, isp, wc, i[1:0], alu, sig};
    endfunction

    task automatic check(input string tag);
        logic [28:0] obs, exp;
        obs = {cycle, M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC, RS, ALU, SIG};
        exp = model(inst, carry, expCycle);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%h carry=%0d observed=%h expected=%h", tag, inst, carry, obs, exp);
        end
    endtask

    // One rising edge; inputs are changed 1ns after it and sampled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        expCycle = rst ? 1'b0 : (inst[7] & ~expCycle);
        #1;
    endtask

    task automatic chkAt(input string tag);
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        rst = 1'b1; inst = 8'h00; carry = 1'b0; expCycle = 1'b0;
        #2 check("reset_async");
        chkAt("reset_0x00");
        cyc(); inst = 8'hA0; chkAt("reset_mc_eq_i7");
        cyc(); rst = 1'b0; inst = 8'h1B; chkAt("sig_0x1B");
        cyc(); inst = 8'h16; chkAt("lj_0x16");
        cyc(); chkAt("lj_0x16_hold");
        cyc(); inst = 8'hA0; chkAt("mem_ph0");
        cyc(); chkAt("mem_ph1");
        cyc(); chkAt("mem_wrap");
        cyc(); inst = 8'hF0; chkAt("jmp_skip");
        cyc(); inst = 8'hF0; chkAt("jmp_ph0");
        cyc(); carry = 1'b1; chkAt("jmp_ph1_c1");
        carry = 1'b0; #1 check("jmp_ph1_c0");
        cyc(); inst = 8'h0C; chkAt("rdwr_0x0C");
        cyc(); inst = 8'hA0; chkAt("abort_ph0");
        cyc(); chkAt("abort_ph1");
        #1 rst = 1'b1; expCycle = 1'b0; #1 check("abort_rst");
        cyc(); rst = 1'b0; chkAt("abort_restart");
        cyc(); chkAt("abort_restart_ph1");
        cyc();

        // Random stream; i7=1 bytes are held across both phases.
        for (int n = 0; n < 300; n++) begin
            inst = 8'($urandom); carry = 1'($urandom);
            chkAt("rand_ph0");
            if ($urandom_range(0, 19) == 0) begin
                #1 rst = 1'b1; expCycle = 1'b0; #1 check("rand_rst");
                cyc(); rst = 1'b0;
                if (inst[7]) begin cyc(); end
            end else if (inst[7]) begin
                cyc(); carry = 1'($urandom); chkAt("rand_ph1");
                cyc();
            end else begin
                cyc();
            end
        end
        check("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
